iomem_copy_master: RTL and testbench
====================================

Name: iomem_copy_master

Overview:
- Bus initiator for the iomem native-handshake bus, the other end of the responders on that bus (GPIO, RNG, user RAM).
- Performs word copies: reads from a source address, then writes the word to a destination address, repeated `cfg_len` times.
- Intended use is filling user RAM (0x0300_2000) from the RNG data port (0x0300_1000) without CPU load.
- Sits beside the CPU on an arbitrated iomem port.

Parameters:
- LEN_BITS, 16, width of the word-count input and progress counter.
- TIMEOUT, 1024, max cycles m_valid may stay high without m_ready before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; launches a copy when idle
- cfg_src  input  32  first source byte address (word aligned)
- cfg_dst  input  32  first destination byte address (word aligned)
- cfg_len  input  LEN_BITS  number of words to copy
- cfg_src_inc  input  1  1: source += 4 per word; 0: fixed (FIFO/RNG port)
- cfg_dst_inc  input  1  1: destination += 4 per word; 0: fixed
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at completion or abort
- error  output  1  set on timeout abort; held until the next accepted start
- words_done  output  LEN_BITS  words fully written in the current or last copy
- m_valid  output  1  bus request
- m_ready  input  1  responder completion strobe
- m_wstrb  output  4  0000 = read, 1111 = write
- m_addr  output  32  bus address
- m_wdata  output  32  write data
- m_rdata  input  32  read data, valid when m_ready=1

Behaviour:
- Reset (async, immediate):
  - state=IDLE; busy=0, done=0, error=0, words_done=0.
  - m_valid=0, m_wstrb=0, m_addr=0, m_wdata=0.
  - Reset mid-transaction drops m_valid in the same instant.
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FIN.
- IDLE:
  - On start=1, latch cfg_* into working registers and clear error and words_done.
  - If the latched len=0, go to FIN with no bus activity.
  - Otherwise go to RD_REQ.
  - start while not IDLE is ignored; cfg_* changes during a copy have no effect.
- RD_REQ:
  - m_valid=1, m_wstrb=0000, m_addr=src.
  - On the edge where m_ready=1: capture m_rdata into the data register, go to RD_GAP.
- RD_GAP:
  - m_valid=0 for exactly one cycle, required because responders use valid&&!ready.
  - If src_inc=1, src+=4 (mod 2^32, wraps).
  - Go to WR_REQ.
- WR_REQ:
  - m_valid=1, m_wstrb=1111, m_addr=dst, m_wdata=data register.
  - On m_ready=1: words_done+=1, go to WR_GAP.
- WR_GAP:
  - m_valid=0 for one cycle.
  - If dst_inc=1, dst+=4 (wraps).
  - If words_done==len, go to FIN; else go to RD_REQ.
- FIN: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Bus rules:
  - m_addr, m_wstrb and m_wdata are stable for the whole time m_valid=1.
  - m_ready is ignored while m_valid=0.
- Per-word latency: (Lr+1)+(Lw+1) cycles, where Lr and Lw are the cycles from valid rise to ready.
- Timeout:
  - A counter clears whenever m_valid rises and increments each cycle m_valid=1 && m_ready=0.
  - When it reaches TIMEOUT (and TIMEOUT≠0): m_valid=0 on the next cycle, error=1, go to FIN.
  - words_done keeps the count of completed words.
  - m_ready arriving in the same cycle the count hits TIMEOUT counts as success; ready has priority.
- Max len = 2^LEN_BITS-1.
- words_done never wraps; it compares against the latched len.

Test Plan:
- Copy src=0x0300_1000 (src_inc=0), dst=0x0300_2000 (dst_inc=1), len=4, responder ready after 1 cycle, RNG model returns 0xA0..A3 -> 4 reads at 0x0300_1000; writes of A0..A3 to 0x0300_2000/2004/2008/200C with wstrb 1111; m_valid low ≥1 cycle between requests; done pulses once; words_done=4; error=0.
- start with len=0 -> no m_valid ever; busy one cycle, done pulse 2 cycles after start; words_done=0.
- TIMEOUT=8, responder never asserts ready on the first write -> m_valid high exactly 8 cycles then drops; error=1, done=1, words_done=0; next start clears error.
- start pulsed again while busy with different cfg values -> ignored; the original copy completes unchanged.
- Async reset asserted during WR_REQ of word 2 -> m_valid=0 immediately; busy, done and words_done read 0; after release the block idles until a new start.
- src=0xFFFF_FFFC, src_inc=1, len=2 -> reads at 0xFFFF_FFFC then 0x0000_0000 (wrap).

Source files
------------

// File: rtl/iomem_copy_master.sv
// iomem_copy_master
//   Bus initiator on the iomem native-handshake bus. Copies cfg_len words
//   one at a time: read a word from the source address, then write it to the
//   destination address. Either address may advance by 4 per word or stay
//   fixed, so a FIFO-style port such as the RNG data register can feed RAM.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start             one-cycle launch pulse (only honoured when idle)
//   cfg_src/cfg_dst   first source / destination byte address (word aligned)
//   cfg_len           number of words to copy
//   cfg_src_inc       1: source advances by 4 per word, 0: fixed
//   cfg_dst_inc       1: destination advances by 4 per word, 0: fixed
//   busy              copy in progress
//   done              one-cycle pulse at completion or abort
//   error             timeout abort flag, held until the next accepted start
//   words_done        words fully written in the current / last copy
//   m_valid..m_rdata  iomem initiator side (request, ready strobe, wstrb,
//                     address, write data, read data)
module iomem_copy_master #(
  parameter int LEN_BITS = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         cfg_src,
  input  logic [31:0]         cfg_dst,
  input  logic [LEN_BITS-1:0] cfg_len,
  input  logic                cfg_src_inc,
  input  logic                cfg_dst_inc,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_BITS-1:0] words_done,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [3:0]          m_wstrb,
  output logic [31:0]         m_addr,
  output logic [31:0]         m_wdata,
  input  logic [31:0]         m_rdata
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FIN} state_t;

  // The wait counter only has to hold 0..TIMEOUT-1; the abort fires on the
  // cycle it would step to TIMEOUT.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t              state;
  state_t              state_next;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [31:0]         data;
  logic [LEN_BITS-1:0] len;
  logic                src_inc;
  logic                dst_inc;
  logic [TW-1:0]       tcnt;
  logic                in_req;
  logic                timeout_hit;

  assign in_req = (state == RD_REQ) || (state == WR_REQ);

  // Ready wins over the timeout when both land in the same cycle.
  assign timeout_hit = (TIMEOUT != 0) && in_req && !m_ready && (tcnt == TLAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (cfg_len == '0) ? FIN : RD_REQ;
        end
      end
      RD_REQ: begin
        if (m_ready) begin
          state_next = RD_GAP;
        end else if (timeout_hit) begin
          state_next = FIN;
        end
      end
      RD_GAP: state_next = WR_REQ;
      WR_REQ: begin
        if (m_ready) begin
          state_next = WR_GAP;
        end else if (timeout_hit) begin
          state_next = FIN;
        end
      end
      // words_done was already bumped on the accepting edge of WR_REQ.
      WR_GAP:  state_next = (words_done == len) ? FIN : RD_REQ;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state: the request drops the instant the state
  // leaves a *_REQ state, including on asynchronous reset. Address, strobe
  // and data come from registers that do not change while in a REQ state.
  always_comb begin
    busy    = (state != IDLE);
    m_valid = in_req;
    m_wstrb = 4'b0000;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (state == RD_REQ) begin
      m_addr = src;
    end else if (state == WR_REQ) begin
      m_wstrb = 4'b1111;
      m_addr  = dst;
      m_wdata = data;
    end
  end

  // Working registers, status and the wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src        <= 32'd0;
      dst        <= 32'd0;
      data       <= 32'd0;
      len        <= '0;
      src_inc    <= 1'b0;
      dst_inc    <= 1'b0;
      error      <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
      tcnt       <= '0;
    end else begin
      // done follows FIN by one cycle, so it coincides with busy falling.
      done <= (state == FIN);

      case (state)
        IDLE: begin
          if (start) begin
            src        <= cfg_src;
            dst        <= cfg_dst;
            len        <= cfg_len;
            src_inc    <= cfg_src_inc;
            dst_inc    <= cfg_dst_inc;
            error      <= 1'b0;
            words_done <= '0;
          end
        end
        RD_REQ: begin
          if (m_ready) begin
            data <= m_rdata;
          end
        end
        RD_GAP: begin
          if (src_inc) begin
            src <= src + 32'd4;
          end
        end
        WR_REQ: begin
          if (m_ready) begin
            words_done <= words_done + 1'b1;
          end
        end
        WR_GAP: begin
          if (dst_inc) begin
            dst <= dst + 32'd4;
          end
        end
        default: ;
      endcase

      if (timeout_hit) begin
        error <= 1'b1;
      end

      // Outside a request the counter sits at zero, so every rise of
      // m_valid starts counting from a clean slate.
      if ((TIMEOUT != 0) && in_req && !m_ready) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iomem_copy_master.sv
module tb_iomem_copy_master;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] cfg_src;
  logic [31:0] cfg_dst;
  logic [15:0] cfg_len;
  logic        cfg_src_inc;
  logic        cfg_dst_inc;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_done;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  iomem_copy_master #(.LEN_BITS(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_src_inc(cfg_src_inc), .cfg_dst_inc(cfg_dst_inc),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- responder model ----------------
  // Driven on the falling edge: raises m_ready once the request has been
  // visible for `lat` cycles. Reads return 0xA0 + global read index.
  int          lat      = 1;
  bit          never_wr = 0;
  int          nrd      = 0;
  int          nwr      = 0;
  int          rises    = 0;
  int          gap_bad  = 0;
  int          stab_bad = 0;
  int          run      = 0;
  int          last_run = 0;
  int          done_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_strb;
  logic [31:0] rd_addr_log [0:63];
  logic [31:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  logic [3:0]  wr_strb_log [0:63];
  int          run_now;

  assign run_now = prev_valid ? run + 1 : 1;

  initial begin
    m_ready = 1'b0;
    m_rdata = 32'd0;
  end

  always @(negedge clk) begin
    m_ready <= 1'b0;
    if (m_valid) begin
      // ready was offered last cycle, so the request must have dropped
      if (m_ready) gap_bad <= gap_bad + 1;
      if (!prev_valid) begin
        rises   <= rises + 1;
        s_addr  <= m_addr;
        s_strb  <= m_wstrb;
        s_wdata <= m_wdata;
      end else if (m_addr !== s_addr || m_wstrb !== s_strb || m_wdata !== s_wdata) begin
        stab_bad <= stab_bad + 1;
      end
      run <= run_now;
      if (!m_ready && run_now >= lat && !(never_wr && m_wstrb == 4'hF)) begin
        m_ready <= 1'b1;
        if (m_wstrb == 4'h0) begin
          if (nrd < 64) rd_addr_log[nrd] <= m_addr;
          m_rdata <= 32'hA0 + 32'(nrd);
          nrd <= nrd + 1;
        end else begin
          if (nwr < 64) begin
            wr_addr_log[nwr] <= m_addr;
            wr_data_log[nwr] <= m_wdata;
            wr_strb_log[nwr] <= m_wstrb;
          end
          nwr <= nwr + 1;
        end
      end
    end else if (prev_valid) begin
      last_run <= run;
    end
    prev_valid <= m_valid;
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input logic si, input logic di);
    @(negedge clk);
    cfg_src = s; cfg_dst = d; cfg_len = n; cfg_src_inc = si; cfg_dst_inc = di;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("copy src=%h dst=%h len=%0d si=%0b di=%0b", s, d, n, si, di);
  endtask

  // Waits for the done pulse, then one more cycle so monitor counters settle.
  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  int rb, wb, db, rz;

  initial begin
    reset = 1'b1; start = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_src_inc = 1'b0; cfg_dst_inc = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_done), 32'd0);
    chk("rst_addr",  m_addr, 32'd0);
    chk("rst_wstrb", 32'(m_wstrb), 32'd0);
    chk("rst_wdata", m_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1) RNG -> RAM, 4 words, fixed source, incrementing destination
    lat = 1;
    rb = nrd; wb = nwr; db = done_cnt;
    do_copy(32'h0300_1000, 32'h0300_2000, 16'd4, 1'b0, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1");
    chk("t1_nrd", 32'(nrd - rb), 32'd4);
    chk("t1_nwr", 32'(nwr - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_rd_addr%0d", i), rd_addr_log[rb + i], 32'h0300_1000);
      chk($sformatf("t1_wr_addr%0d", i), wr_addr_log[wb + i], 32'h0300_2000 + 32'(4 * i));
      chk($sformatf("t1_wr_data%0d", i), wr_data_log[wb + i], 32'hA0 + 32'(i));
      chk($sformatf("t1_wr_strb%0d", i), 32'(wr_strb_log[wb + i]), 32'hF);
    end
    chk("t1_words", 32'(words_done), 32'd4);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_done_cnt", 32'(done_cnt - db), 32'd1);
    chk("t1_gap", 32'(gap_bad), 32'd0);
    chk("t1_stable", 32'(stab_bad), 32'd0);

    // 2) len = 0: no bus traffic, busy one cycle, done two cycles after start
    rz = rises;
    do_copy(32'h0300_1000, 32'h0300_2000, 16'd0, 1'b0, 1'b1);
    chk("t2_busy1", 32'(busy), 32'd1);
    chk("t2_done1", 32'(done), 32'd0);
    @(negedge clk);
    chk("t2_busy2", 32'(busy), 32'd0);
    chk("t2_done2", 32'(done), 32'd1);
    chk("t2_words", 32'(words_done), 32'd0);
    @(negedge clk);
    chk("t2_done3", 32'(done), 32'd0);
    chk("t2_rises", 32'(rises - rz), 32'd0);

    // 3) start while busy with other cfg is ignored
    lat = 2;
    rb = nrd; wb = nwr; db = done_cnt;
    do_copy(32'h0300_1000, 32'h0300_2100, 16'd2, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    cfg_src = 32'h1111_0000; cfg_dst = 32'h2222_0000; cfg_len = 16'd7;
    cfg_src_inc = 1'b1; cfg_dst_inc = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3");
    chk("t3_nwr", 32'(nwr - wb), 32'd2);
    chk("t3_rd_addr1", rd_addr_log[rb + 1], 32'h0300_1000);
    chk("t3_wr_addr0", wr_addr_log[wb], 32'h0300_2100);
    chk("t3_wr_addr1", wr_addr_log[wb + 1], 32'h0300_2104);
    chk("t3_wr_data1", wr_data_log[wb + 1], 32'hA0 + 32'(rb + 1));
    chk("t3_words", 32'(words_done), 32'd2);
    chk("t3_done_cnt", 32'(done_cnt - db), 32'd1);
    rz = rises;
    repeat (5) @(negedge clk);
    chk("t3_no_restart", 32'(rises - rz), 32'd0);

    // 4) source address wraps past 0xFFFF_FFFC
    lat = 1;
    rb = nrd; wb = nwr;
    do_copy(32'hFFFF_FFFC, 32'h0300_2000, 16'd2, 1'b1, 1'b0);
    wait_done("t4");
    chk("t4_rd_addr0", rd_addr_log[rb], 32'hFFFF_FFFC);
    chk("t4_rd_addr1", rd_addr_log[rb + 1], 32'h0000_0000);
    chk("t4_wr_addr1", wr_addr_log[wb + 1], 32'h0300_2000);
    chk("t4_words", 32'(words_done), 32'd2);

    // 5) write never acknowledged: abort after 8 cycles of m_valid
    lat = 1; never_wr = 1;
    wb = nwr; db = done_cnt;
    do_copy(32'h0300_1000, 32'h0300_2000, 16'd3, 1'b0, 1'b1);
    wait_done("t5");
    chk("t5_valid_len", 32'(last_run), 32'd8);
    chk("t5_error", 32'(error), 32'd1);
    chk("t5_words", 32'(words_done), 32'd0);
    chk("t5_nwr", 32'(nwr - wb), 32'd0);
    chk("t5_done_cnt", 32'(done_cnt - db), 32'd1);
    chk("t5_valid_low", 32'(m_valid), 32'd0);
    never_wr = 0;
    do_copy(32'h0300_1000, 32'h0300_2000, 16'd1, 1'b0, 1'b1);
    chk("t5_err_clr", 32'(error), 32'd0);
    wait_done("t5b");
    chk("t5b_error", 32'(error), 32'd0);
    chk("t5b_words", 32'(words_done), 32'd1);

    // 6) asynchronous reset during the second word's write request
    lat = 6;
    wb = nwr;
    do_copy(32'h0300_1000, 32'h0300_2000, 16'd4, 1'b0, 1'b1);
    begin
      bit hit = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (nwr == wb + 1 && m_valid && m_wstrb == 4'hF) begin
          hit = 1;
          break;
        end
      end
      chk("t6_reached_wr2", 32'(hit), 32'd1);
    end
    chk("t6_words_pre", 32'(words_done), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_words", 32'(words_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rz = rises;
    repeat (6) @(negedge clk);
    chk("t6_idle_rises", 32'(rises - rz), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
